mod_updown_counter: RTL

Parametrised up/down counter with a programmable modulus, programmable step, synchronous load, a built-in prescaler and a registered terminal-count pulse. It is the general-purpose successor to the fixed-range 8-bit up/down counter. It serves timers, address sequencers and rate dividers in the same designs. An optional saturating mode replaces wrap-around at the range limits.

---
 rtl/counter_pkg.sv | 11 +
 rtl/count_prescaler.sv | 29 ++
 rtl/mod_updown_counter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter family: wrap/saturate mode
// encodings and the boundary selects used when a count clamps.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic BOUND_ZERO = 1'b0;
    localparam logic BOUND_MOD  = 1'b1;

endpackage

// File: rtl/count_prescaler.sv
// Prescaler for the up/down counter: divides enabled cycles by
// prescale+1 and emits a one-cycle advance tick.
module count_prescaler #(
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pc;

    assign tick = enable && (pc >= prescale);

    // pc counts enabled cycles and restarts on every tick or clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (clear) begin
            pc <= '0;
        end else if (enable) begin
            pc <= tick ? '0 : pc + 1'b1;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, step, load and prescaler.
// Define COUNTER_SAT_EN to add the satMode port and saturating limits.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH    = 8,
    parameter int STEP_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      upDown,
    input  logic                      load,
    input  logic [COUNT_WIDTH-1:0]    loadValue,
    input  logic [COUNT_WIDTH-1:0]    modulus,
    input  logic [STEP_WIDTH-1:0]     step,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef COUNTER_SAT_EN
    input  logic                      satMode,
`endif
    output logic [COUNT_WIDTH-1:0]    countOut,
    output logic                      tc,
    output logic                      atMax,
    output logic                      atMin
);

    localparam int CW1 = COUNT_WIDTH + 1;
    localparam int EW  = (CW1 > STEP_WIDTH) ? CW1 : STEP_WIDTH;

    logic                   tick;
    logic                   mode;
    logic [EW-1:0]          step_w;
    logic [EW-1:0]          mod_w;
    logic [CW1-1:0]         cnt_x;
    logic [CW1-1:0]         mod_x;
    logic [CW1-1:0]         eff_x;
    logic [CW1-1:0]         sum_x;
    logic [CW1-1:0]         short_x;
    logic [COUNT_WIDTH-1:0] ld_val;
    logic [COUNT_WIDTH-1:0] nxt;
    logic                   nxt_tc;

`ifdef COUNTER_SAT_EN
    assign mode = satMode;
`else
    assign mode = MODE_WRAP;
`endif

    function automatic logic [COUNT_WIDTH-1:0] bound(
        input logic                   sel,
        input logic [COUNT_WIDTH-1:0] m
    );
        return (sel == BOUND_MOD) ? m : '0;
    endfunction

    count_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_pre (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .clear   (load),
        .prescale(prescale),
        .tick    (tick)
    );

    assign atMax = (countOut == modulus);
    assign atMin = (countOut == '0);

    assign ld_val = (loadValue > modulus) ? modulus : loadValue;

    // Clip the step to the modulus; all sums are one bit wider
    always_comb begin
        step_w  = EW'(step);
        mod_w   = EW'(modulus);
        cnt_x   = CW1'(countOut);
        mod_x   = CW1'(modulus);
        eff_x   = (step_w > mod_w) ? mod_x : CW1'(step);
        sum_x   = cnt_x + eff_x;
        short_x = eff_x - cnt_x;
    end

    // Next count and boundary flag for one advance
    always_comb begin
        nxt    = countOut;
        nxt_tc = 1'b0;
        if (cnt_x > mod_x) begin
            nxt    = bound(upDown ? BOUND_ZERO : BOUND_MOD, modulus);
            nxt_tc = 1'b1;
        end else if (upDown) begin
            if (sum_x <= mod_x) begin
                nxt = COUNT_WIDTH'(sum_x);
            end else begin
                nxt_tc = 1'b1;
                if (mode == MODE_SAT)
                    nxt = bound(BOUND_MOD, modulus);
                else
                    nxt = COUNT_WIDTH'(sum_x - mod_x - CW1'(1));
            end
        end else begin
            if (cnt_x >= eff_x) begin
                nxt = COUNT_WIDTH'(cnt_x - eff_x);
            end else begin
                nxt_tc = 1'b1;
                if (mode == MODE_SAT)
                    nxt = bound(BOUND_ZERO, modulus);
                else
                    nxt = COUNT_WIDTH'(mod_x + CW1'(1) - short_x);
            end
        end
    end

    // Count register: load beats advance, tc pulses only on boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countOut <= '0;
            tc       <= 1'b0;
        end else if (load) begin
            countOut <= ld_val;
            tc       <= 1'b0;
        end else if (tick) begin
            countOut <= nxt;
            tc       <= nxt_tc;
        end else begin
            tc       <= 1'b0;
        end
    end

endmodule
